// File: rtl/net_rate_limiter.sv
// Token-bucket flit limiter for a NIC transmit stream. Each accepted flit costs one token.
// The bucket refills every rlimit_period cycles. The output is a single registered slot.
module net_rate_limiter #(
  parameter int DATA_W = 64,
  parameter int KEEP_W = 8,
  parameter int CNT_W  = 8
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [KEEP_W-1:0] in_keep,
  input  logic              in_last,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [KEEP_W-1:0] out_keep,
  output logic              out_last,
  input  logic [CNT_W-1:0]  rlimit_inc,
  input  logic [CNT_W-1:0]  rlimit_period,
  input  logic [CNT_W-1:0]  rlimit_size,
  output logic [31:0]       pkt_count
);

  logic [CNT_W-1:0]  tok_q, tok_d;
  logic [CNT_W-1:0]  cyc_q, cyc_d;
  logic [CNT_W-1:0]  period_eff;
  logic [CNT_W:0]    tok_sum;
  logic              refill, acc, out_fire;

  logic              out_valid_q, out_valid_d;
  logic [DATA_W-1:0] out_data_q, out_data_d;
  logic [KEEP_W-1:0] out_keep_q, out_keep_d;
  logic              out_last_q, out_last_d;
  logic [31:0]       pkt_q, pkt_d;

  // A runtime period drop below the current count wraps on the next cycle via >=.
  always_comb begin
    period_eff = (rlimit_period == '0) ? CNT_W'(1) : rlimit_period;
    refill     = (cyc_q >= period_eff - CNT_W'(1));
    cyc_d      = refill ? '0 : cyc_q + CNT_W'(1);
  end

  always_comb begin
    in_ready = !reset && (tok_q != '0) && (rlimit_size != '0) && (!out_valid_q || out_ready);
    acc      = in_valid && in_ready;
    out_fire = out_valid_q && out_ready;
    // Consume, then add, then clamp, all one bit wider so nothing wraps.
    tok_sum  = {1'b0, tok_q} - {{CNT_W{1'b0}}, acc} + (refill ? {1'b0, rlimit_inc} : '0);
    tok_d    = (tok_sum > {1'b0, rlimit_size}) ? rlimit_size : tok_sum[CNT_W-1:0];
  end

  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_keep_d  = out_keep_q;
    out_last_d  = out_last_q;
    pkt_d       = pkt_q;
    if (out_fire && out_last_q) pkt_d = pkt_q + 32'd1;
    if (acc) begin
      out_valid_d = 1'b1;
      out_data_d  = in_data;
      out_keep_d  = in_keep;
      out_last_d  = in_last;
    end else if (out_fire) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      tok_q       <= '0;
      cyc_q       <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_keep_q  <= '0;
      out_last_q  <= 1'b0;
      pkt_q       <= '0;
    end else begin
      tok_q       <= tok_d;
      cyc_q       <= cyc_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_keep_q  <= out_keep_d;
      out_last_q  <= out_last_d;
      pkt_q       <= pkt_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_keep  = out_keep_q;
  assign out_last  = out_last_q;
  assign pkt_count = pkt_q;

endmodule
